// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline constants for the five-stage MIPS core: Tuse/Tnew encodings,
// mult/div latencies and the hard-wired zero register.
package mips_pipe_pkg;

    localparam logic [1:0] TUSE_D = 2'd0;
    localparam logic [1:0] TUSE_E = 2'd1;
    localparam logic [1:0] TUSE_M = 2'd2;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-unit bundle: D/E/M register fields in, freeze/flush controls and
// statistics out. The pipeline (or a bench) is master, the hazard unit slave.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       d_rs;
    logic [4:0]       d_rt;
    logic             d_use_rs;
    logic             d_use_rt;
    logic [1:0]       d_tuse_rs;
    logic [1:0]       d_tuse_rt;
    logic             d_is_md;
    logic [4:0]       e_wa;
    logic [1:0]       e_tnew;
    logic [4:0]       m_wa;
    logic [1:0]       m_tnew;
    logic             e_md_start;
    logic             e_md_div;
    logic             pc_freeze;
    logic             fd_freeze;
    logic             de_flush;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt, d_is_md,
               e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_div,
        input  pc_freeze, fd_freeze, de_flush, md_busy, stall_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt, d_is_md,
               e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_div,
        output pc_freeze, fd_freeze, de_flush, md_busy, stall_cnt
    );

endinterface

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Mult/div busy tracker: loads the unit latency on a start from idle and
// counts down to zero; md_busy is high while the count is non-zero.
module md_busy_counter
    import mips_pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic md_busy
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    md_state_e     state_r;
    md_state_e     state_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic [CW-1:0] load_s;
    logic          busy_r;

    // Next-state: load on a start from idle, ignore starts while counting down
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        load_s      = MULT_LOAD;
        if (is_div) begin
            load_s = DIV_LOAD;
        end else begin
            load_s = MULT_LOAD;
        end
        case (state_r)
            MD_IDLE: begin
                if (start && (load_s != CNT_ZERO)) begin
                    count_nxt_s = load_s;
                    state_nxt_s = MD_BUSY;
                end else begin
                    count_nxt_s = CNT_ZERO;
                    state_nxt_s = MD_IDLE;
                end
            end
            MD_BUSY: begin
                count_nxt_s = count_r - CNT_ONE;
                if (count_r == CNT_ONE) begin
                    state_nxt_s = MD_IDLE;
                end else begin
                    state_nxt_s = MD_BUSY;
                end
            end
            default: begin
                count_nxt_s = CNT_ZERO;
                state_nxt_s = MD_IDLE;
            end
        endcase
    end

    // State, count and the registered busy flag; reset abandons any busy period
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MD_IDLE;
            count_r <= CNT_ZERO;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            busy_r  <= (count_nxt_s != CNT_ZERO);
        end
    end

    assign md_busy = busy_r;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller: combinational RAW (Tuse/Tnew) and mult/div stall decision
// driving PC/F-D freeze and D/E flush, plus a saturating stall-cycle counter.
module hazard_stall_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             rs_stall_s;
    logic             rt_stall_s;
    logic             md_stall_s;
    logic             stall_s;
    logic             md_busy_s;
    logic [CNT_W-1:0] stall_cnt_r;

    // rs hazard: a younger-needed operand whose producer is not ready yet
    always_comb begin
        rs_stall_s = 1'b0;
        if (bus.d_use_rs && (bus.d_rs != REG_ZERO)) begin
            rs_stall_s = ((bus.e_wa == bus.d_rs) && (bus.d_tuse_rs < bus.e_tnew)) ||
                         ((bus.m_wa == bus.d_rs) && (bus.d_tuse_rs < bus.m_tnew));
        end else begin
            rs_stall_s = 1'b0;
        end
    end

    // rt hazard: same rule as rs
    always_comb begin
        rt_stall_s = 1'b0;
        if (bus.d_use_rt && (bus.d_rt != REG_ZERO)) begin
            rt_stall_s = ((bus.e_wa == bus.d_rt) && (bus.d_tuse_rt < bus.e_tnew)) ||
                         ((bus.m_wa == bus.d_rt) && (bus.d_tuse_rt < bus.m_tnew));
        end else begin
            rt_stall_s = 1'b0;
        end
    end

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy (
        .clk     (clk),
        .reset   (reset),
        .start   (bus.e_md_start),
        .is_div  (bus.e_md_div),
        .md_busy (md_busy_s)
    );

    // A starting mult/div in E also blocks a dependent md instruction in D
    assign md_stall_s = bus.d_is_md && (md_busy_s || bus.e_md_start);
    assign stall_s    = rs_stall_s || rt_stall_s || md_stall_s;

    // Stall statistics, saturating at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.pc_freeze = stall_s;
    assign bus.fd_freeze = stall_s;
    assign bus.de_flush  = stall_s;
    assign bus.md_busy   = md_busy_s;
    assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed test-plan scenarios followed by random traffic, all checked against
// a cycle-indexed reference model of the hazard rules.
module tb_hazard_stall_ctrl;
    import mips_pipe_pkg::*;

    localparam int CW     = 6;
    localparam int CMAX   = (1 << CW) - 1;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(CW)) hif ();

    hazard_stall_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state: busy while cycle index < busy_end; m_cnt is the stall total
    int mcyc     = 0;
    int busy_end = 0;
    int m_cnt    = 0;
    bit chk_en   = 1'b0;

    logic          obs_stall;
    logic          obs_busy;
    logic [CW-1:0] obs_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit src_hazard(input bit use_s, input int r, input int tuse);
        if (!use_s || r == 0) return 1'b0;
        if (r == int'(hif.e_wa) && tuse < int'(hif.e_tnew)) return 1'b1;
        if (r == int'(hif.m_wa) && tuse < int'(hif.m_tnew)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        hif.d_rs = 5'd0; hif.d_rt = 5'd0; hif.d_use_rs = 1'b0; hif.d_use_rt = 1'b0;
        hif.d_tuse_rs = TUSE_D; hif.d_tuse_rt = TUSE_D; hif.d_is_md = 1'b0;
        hif.e_wa = 5'd0; hif.e_tnew = 2'd0; hif.m_wa = 5'd0; hif.m_tnew = 2'd0;
        hif.e_md_start = 1'b0; hif.e_md_div = 1'b0;
    endtask

    // One clock: check at negedge, then advance the model at the posedge
    task automatic cycle();
        bit exp_busy;
        bit exp_stall;
        @(negedge clk);
        exp_busy  = (mcyc < busy_end);
        exp_stall = src_hazard(hif.d_use_rs, int'(hif.d_rs), int'(hif.d_tuse_rs)) ||
                    src_hazard(hif.d_use_rt, int'(hif.d_rt), int'(hif.d_tuse_rt)) ||
                    (hif.d_is_md && (exp_busy || hif.e_md_start));
        obs_stall = hif.pc_freeze;
        obs_busy  = hif.md_busy;
        obs_cnt   = hif.stall_cnt;
        if (chk_en) begin
            check_val("pc_freeze", 32'(hif.pc_freeze), 32'(exp_stall));
            check_val("fd_freeze", 32'(hif.fd_freeze), 32'(exp_stall));
            check_val("de_flush",  32'(hif.de_flush),  32'(exp_stall));
            check_val("md_busy",   32'(hif.md_busy),   32'(exp_busy));
            check_val("stall_cnt", 32'(hif.stall_cnt), 32'(m_cnt));
        end
        @(posedge clk);
        mcyc++;
        if (reset) begin
            busy_end = 0;
            m_cnt    = 0;
        end else begin
            if (hif.e_md_start && !exp_busy)
                busy_end = mcyc + (hif.e_md_div ? DIV_N : MULT_N);
            if (exp_stall && m_cnt < CMAX)
                m_cnt++;
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_st;
        int n_busy;
        reset = 1'b1;
        idle_inputs();
        cycle();
        cycle();
        chk_en = 1'b1;
        reset  = 1'b0;

        cycle();
        check_val("rst_busy", 32'(obs_busy), 32'd0);
        check_val("rst_cnt",  32'(obs_cnt),  32'd0);

        // Load-use, then the same register now forwardable from M
        hif.d_rs = 5'd8; hif.d_use_rs = 1'b1; hif.d_tuse_rs = TUSE_D;
        hif.e_wa = 5'd8; hif.e_tnew = 2'd2;
        cycle();
        check_val("load_use_stall", 32'(obs_stall), 32'd1);
        hif.d_tuse_rs = TUSE_E; hif.e_wa = 5'd0; hif.e_tnew = 2'd0;
        hif.m_wa = 5'd8; hif.m_tnew = 2'd1;
        cycle();
        check_val("load_use_next", 32'(obs_stall), 32'd0);
        check_val("load_use_cnt",  32'(obs_cnt),   32'd1);

        idle_inputs();
        hif.d_rs = 5'd0; hif.d_use_rs = 1'b1; hif.e_wa = 5'd0; hif.e_tnew = 2'd2;
        cycle();
        check_val("zero_reg", 32'(obs_stall), 32'd0);

        idle_inputs();
        hif.d_rt = 5'd9; hif.d_use_rt = 1'b1; hif.d_tuse_rt = TUSE_E;
        hif.e_wa = 5'd9; hif.e_tnew = 2'd1;
        cycle();
        check_val("forwardable", 32'(obs_stall), 32'd0);
        hif.e_tnew = 2'd2;
        cycle();
        check_val("rt_e_stall", 32'(obs_stall), 32'd1);

        // Div followed by mflo
        do_reset();
        hif.d_is_md = 1'b1; hif.e_md_start = 1'b1; hif.e_md_div = 1'b1;
        cycle();
        n_st = int'(obs_stall);
        hif.e_md_start = 1'b0;
        for (int i = 0; i < DIV_N; i++) begin
            cycle();
            n_st += int'(obs_stall);
            check_val("div_busy", 32'(obs_busy), 32'd1);
        end
        cycle();
        check_val("div_stall_cycles", 32'(n_st), 32'd11);
        check_val("div_done_busy",  32'(obs_busy),  32'd0);
        check_val("div_done_stall", 32'(obs_stall), 32'd0);
        check_val("div_done_cnt",   32'(obs_cnt),   32'd11);

        // Mult with an unrelated instruction in D
        do_reset();
        hif.e_md_start = 1'b1; hif.e_md_div = 1'b0;
        cycle();
        check_val("mult_start_stall", 32'(obs_stall), 32'd0);
        hif.e_md_start = 1'b0;
        n_busy = 0;
        for (int i = 0; i < MULT_N + 3; i++) begin
            cycle();
            n_busy += int'(obs_busy);
        end
        check_val("mult_busy_cycles", 32'(n_busy), 32'd5);
        check_val("mult_cnt", 32'(obs_cnt), 32'd0);

        // Reset three cycles after a div start
        do_reset();
        hif.d_is_md = 1'b1; hif.e_md_start = 1'b1; hif.e_md_div = 1'b1;
        cycle();
        hif.e_md_start = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check_val("rst_mid_busy",  32'(obs_busy),  32'd0);
        check_val("rst_mid_cnt",   32'(obs_cnt),   32'd0);
        check_val("rst_mid_stall", 32'(obs_stall), 32'd0);

        // Saturation of the stall counter
        do_reset();
        hif.d_is_md = 1'b1; hif.e_md_start = 1'b1; hif.e_md_div = 1'b0;
        for (int i = 0; i < CMAX + 8; i++) cycle();
        check_val("cnt_saturate", 32'(obs_cnt), 32'(CMAX));

        // Random traffic over a small register window to provoke hazards
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            hif.d_rs       = 5'($urandom_range(0, 3));
            hif.d_rt       = 5'($urandom_range(0, 3));
            hif.d_use_rs   = 1'($urandom_range(0, 1));
            hif.d_use_rt   = 1'($urandom_range(0, 1));
            hif.d_tuse_rs  = 2'($urandom_range(0, 2));
            hif.d_tuse_rt  = 2'($urandom_range(0, 2));
            hif.d_is_md    = ($urandom_range(0, 3) == 0);
            hif.e_wa       = 5'($urandom_range(0, 3));
            hif.e_tnew     = 2'($urandom_range(0, 2));
            hif.m_wa       = 5'($urandom_range(0, 3));
            hif.m_tnew     = 2'($urandom_range(0, 1));
            hif.e_md_start = ($urandom_range(0, 7) == 0);
            hif.e_md_div   = 1'($urandom_range(0, 1));
            reset          = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the five-stage MIPS core.
- Decides each cycle whether the PC and the F/D register hold, and whether the D/E register is flushed (a bubble is inserted).
- Sources of stalls:
  - register read-after-write hazards, using Tuse/Tnew comparison;
  - a multi-cycle multiply/divide unit, tracked by an internal busy counter.
- Drives the PC freeze input (1 = hold) directly and keeps a saturating stall-cycle counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 32, width of the stall statistics counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- d_rs  in  5  rs field of instruction in D.
- d_rt  in  5  rt field of instruction in D.
- d_use_rs  in  1  D instruction reads rs.
- d_use_rt  in  1  D instruction reads rt.
- d_tuse_rs  in  2  cycles until rs is needed (0 = in D, 1 = in E, 2 = in M).
- d_tuse_rt  in  2  same, for rt.
- d_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- e_wa  in  5  destination register of E instruction (0 = none).
- e_tnew  in  2  cycles until E result is forwardable.
- m_wa  in  5  destination register of M instruction.
- m_tnew  in  2  cycles until M result is forwardable.
- e_md_start  in  1  E instruction starts mult/div this cycle.
- e_md_div  in  1  qualifies e_md_start: 1 = div, 0 = mult.
- pc_freeze  out  1  to PC en; 1 = hold PC.
- fd_freeze  out  1  hold F/D register.
- de_flush  out  1  clear D/E register (bubble).
- md_busy  out  1  mult/div unit busy.
- stall_cnt  out  CNT_W  total stalled cycles since reset.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - md counter and stall_cnt go to 0.
  - Therefore md_busy=0 and stall_cnt=0 the next cycle.
  - Reset mid mult/div abandons the busy period immediately.
- RAW stall, combinational:
  - For each source s in {rs, rt} with d_use_s=1 and reg≠0:
    - stall if e_wa==reg and d_tuse_s < e_tnew;
    - stall if m_wa==reg and d_tuse_s < m_tnew.
  - Register 0 never stalls.
  - Tnew==0 never stalls.
  - Equal Tuse and Tnew does not stall (the value is forwarded).
- MD stall, combinational: d_is_md && (md_busy || e_md_start).
- stall = RAW stall OR MD stall. All outputs equal stall, same cycle, no latency:
  - pc_freeze = fd_freeze = de_flush = stall.
- MD counter (width ceil(log2(DIV_CYCLES+1))):
  - IDLE, count==0: if e_md_start, load DIV_CYCLES when e_md_div=1, else MULT_CYCLES.
  - BUSY, count>0: decrement by 1 per cycle.
  - e_md_start while BUSY is ignored. It cannot legally occur because the MD stall prevents it.
  - md_busy = (count≠0), registered.
  - A start at edge t gives md_busy=1 for exactly N cycles, from after edge t through edge t+N.
- stall_cnt:
  - Increments at each clk edge where stall=1 and reset=0.
  - Saturates at all-ones; it does not wrap.
- reset and stall in the same cycle: reset wins for registered state. Combinational outputs still follow their inputs.

Decomposition:
- Shared package `mips_pipe_pkg`:
  - Tuse/Tnew encodings (TUSE_D=0, TUSE_E=1, TUSE_M=2);
  - MULT_CYCLES and DIV_CYCLES defaults;
  - register-0 constant.
- One natural sub-module: `md_busy_counter`, containing the load/decrement counter and the md_busy output.
- Hazard compare stays inline, as two identical per-source comparisons.

Test Plan:
- Load-use:
  - Stimulus: d_rs=8, d_use_rs=1, d_tuse_rs=0, e_wa=8, e_tnew=2.
  - Response: stall=1, and stall_cnt increments by 1.
  - Next cycle, M holds m_wa=8, m_tnew=1 with d_tuse_rs=1: stall=0.
- Zero register:
  - Stimulus: d_rs=0, e_wa=0, e_tnew=2.
  - Response: stall=0.
- Forwardable:
  - Stimulus: d_rt=9, d_tuse_rt=1, e_wa=9, e_tnew=1.
  - Response: stall=0.
- Div then mflo:
  - Stimulus: e_md_start=1, e_md_div=1 for one cycle; D holds mflo (d_is_md=1) throughout.
  - Response: stall=1 in the start cycle plus 10 busy cycles (11 cycles total); md_busy falls after 10 cycles; stall_cnt=11.
- Mult busy with a non-md instruction:
  - Stimulus: e_md_start=1, e_md_div=0; D instruction is not md.
  - Response: no stall; md_busy=1 for exactly 5 cycles.
- Reset mid-div:
  - Stimulus: assert reset 3 cycles after a div start.
  - Response: md_busy=0 and stall_cnt=0 after that edge; d_is_md stall clears the same cycle.
